// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle for div_unit.
// DIV_UNSIGNED_EN adds the unsigned_op request bit.
interface div_unit_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef DIV_UNSIGNED_EN
  logic        unsigned_op;

  modport master (output start, a, b, unsigned_op,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  start, a, b, unsigned_op,
                  output hi, lo, busy, done, div_zero);
`else
  modport master (output start, a, b,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  start, a, b,
                  output hi, lo, busy, done, div_zero);
`endif
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider: remainder on hi, quotient on lo, fixed 34-cycle latency.
// Define DIV_UNSIGNED_EN to add the unsigned_op (DIVU) request bit.
module div_unit (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic        r_sa;
  logic        r_sb;
  logic        r_dz;

  logic        w_uns;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_bz;
  logic [32:0] w_trial;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

`ifdef DIV_UNSIGNED_EN
  assign w_uns = bus.unsigned_op;
`else
  assign w_uns = 1'b0;
`endif

  // Unsigned requests simply see both signs as positive, so FIX needs no extra mode.
  assign w_sa    = ~w_uns & bus.a[31];
  assign w_sb    = ~w_uns & bus.b[31];
  assign w_mag_a = w_sa ? (~bus.a + 32'd1) : bus.a;
  assign w_mag_b = w_sb ? (~bus.b + 32'd1) : bus.b;
  assign w_bz    = (bus.b == '0);

  // Shifted remainder is always below 2*divisor, so a 33-bit difference is exact.
  assign w_trial  = {r_rem, r_quo[31]} - {1'b0, r_dvs};
  assign w_fix_lo = (r_sa ^ r_sb) ? (~r_quo + 32'd1) : r_quo;
  assign w_fix_hi = r_sa ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_next = w_bz ? DONE : RUN;
      RUN:  if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_dz  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dz <= w_bz;
            if (!w_bz) begin
              r_sa  <= w_sa;
              r_sb  <= w_sb;
              r_quo <= w_mag_a;
              r_dvs <= w_mag_b;
              r_rem <= '0;
              r_cnt <= 5'd31;
            end
          end
        end
        RUN: begin
          if (!w_trial[32]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= {r_rem[30:0], r_quo[31]};
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_cnt <= r_cnt - 5'd1;
        end
        FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.div_zero = (r_state == DONE) & r_dz;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model checked every cycle,
// plus literal expectations per operation.
module tb_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  div_unit_if bus();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic u,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Reference model: cycles remaining until (and including) the done cycle.
  int          m_left;
  logic        m_dz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_u;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_left == 0) begin
      if (bus.start) begin
`ifdef DIV_UNSIGNED_EN
        m_u = bus.unsigned_op;
`else
        m_u = 1'b0;
`endif
        if (bus.b == 32'd0) begin
          m_left = 1; m_dz = 1'b1;
        end else begin
          ref_div(bus.a, bus.b, m_u, p_lo, p_hi);
          m_left = 34; m_dz = 1'b0;
        end
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_dz) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
    chk("cyc_done", {31'd0, bus.done}, {31'd0, m_left == 1});
    chk("cyc_div_zero", {31'd0, bus.div_zero}, {31'd0, (m_left == 1) && m_dz});
    chk("cyc_hi", bus.hi, m_hi);
    chk("cyc_lo", bus.lo, m_lo);
  end

  task automatic wait_done(input int pulse_at, input logic [31:0] pa, input logic [31:0] pb,
                           output int lat, output int bcnt);
    bit got;
    lat = 0; bcnt = 0; got = 0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      lat = i;
      if (bus.busy) bcnt++;
      if (bus.done) got = 1;
      else begin
        bus.start = (i == pulse_at);
        if (i == pulse_at) begin
          bus.a = pa; bus.b = pb;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic op(input string nm, input logic [31:0] av, input logic [31:0] bv, input logic u,
                    input int pulse_at, input logic [31:0] pa, input logic [31:0] pb,
                    input int exp_lat, input logic [31:0] elo, input logic [31:0] ehi,
                    input logic edz);
    int lat, bcnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
`ifdef DIV_UNSIGNED_EN
    bus.unsigned_op = u;
`else
    if (u) $display("note: unsigned request treated as signed in this build");
`endif
    wait_done(pulse_at, pa, pb, lat, bcnt);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_busy_cycles"}, bcnt, exp_lat);
    chk({nm, "_lo"}, bus.lo, elo);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
  endtask

  initial begin
    int lat, bcnt;
    checks = 0; failures = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
`ifdef DIV_UNSIGNED_EN
    bus.unsigned_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;

    op("pos_pos",   32'd7,        32'd2,        1'b0, 0, '0, '0, 34, 32'd3,        32'd1,        1'b0);
    op("neg_pos",   32'hFFFFFFF9, 32'd2,        1'b0, 0, '0, '0, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op("pos_neg",   32'd7,        32'hFFFFFFFE, 1'b0, 0, '0, '0, 34, 32'hFFFFFFFD, 32'd1,        1'b0);
    op("neg_neg",   32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 0, '0, '0, 34, 32'd2,        32'hFFFFFFFE, 1'b0);
    op("min_m1",    32'h80000000, 32'hFFFFFFFF, 1'b0, 0, '0, '0, 34, 32'h80000000, 32'd0,        1'b0);
    op("m1_min",    32'hFFFFFFFF, 32'h80000000, 1'b0, 0, '0, '0, 34, 32'd0,        32'hFFFFFFFF, 1'b0);
    op("zero_num",  32'd0,        32'd5,        1'b0, 0, '0, '0, 34, 32'd0,        32'd0,        1'b0);
    op("preload",   32'd7,        32'd2,        1'b0, 0, '0, '0, 34, 32'd3,        32'd1,        1'b0);
    op("div_zero",  32'd5,        32'd0,        1'b0, 0, '0, '0, 1,  32'd3,        32'd1,        1'b1);
    op("ign_start", 32'd100,      32'd7,        1'b0, 10, 32'd9, 32'd3, 34, 32'd14,   32'd2,        1'b0);

    // Abort mid-operation with an asynchronous reset, start held through release.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd4;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_done(0, '0, '0, lat, bcnt);
    chk("after_rst_latency", lat, 34);
    chk("after_rst_lo", bus.lo, 32'd2);
    chk("after_rst_hi", bus.hi, 32'd1);

`ifdef DIV_UNSIGNED_EN
    op("divu",      32'hFFFFFFFF, 32'd2, 1'b1, 0, '0, '0, 34, 32'h7FFFFFFF, 32'd1,        1'b0);
    op("div_same",  32'hFFFFFFFF, 32'd2, 1'b0, 0, '0, '0, 34, 32'd0,        32'hFFFFFFFF, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
